// File: rtl/core_out_packer.sv
// Per-core output stage: packs 8-bit samples into 32-bit words and queues them in 8 lane FIFOs.
// Define CORE_OUT_PACKER_OVF_CNT_EN to enable per-lane saturating drop counters on ovf_count.
module core_out_packer #(
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [63:0]  core_dout,
   input  logic [7:0]   core_dout_valid,
   input  logic [7:0]   flush,
   output logic [255:0] data_to_arb,
   output logic [7:0]   empty_to_arb,
   output logic [7:0]   valid_to_arb,
   input  logic [7:0]   rd_en,
   output logic [7:0]   overflow,
   output logic [63:0]  ovf_count
);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

   for (genvar k = 0; k < 8; k++) begin : g_lane
      logic [7:0]        sample;
      logic              in_valid;
      logic              in_flush;
      logic [1:0]        bc;
      logic [31:0]       acc;
      logic [31:0]       merged;
      logic [31:0]       push_word;
      logic              push;
      logic [31:0]       mem [FIFO_DEPTH];
      logic [ADDR_W-1:0] wr_ptr;
      logic [ADDR_W-1:0] rd_ptr;
      logic [ADDR_W:0]   count;
      logic              full;
      logic              pop;
      logic              accept;
      logic              drop;
      logic [31:0]       rd_data;
      logic              rd_valid;
      logic              ovf_flag;

      assign sample   = core_dout[8*k +: 8];
      assign in_valid = core_dout_valid[k];
      assign in_flush = flush[k];

      // The new byte is merged before flush is considered, so valid+flush yields one push.
      always_comb begin
         merged = acc;
         merged[8*bc +: 8] = sample;
         push_word = acc;
         push = 1'b0;
         if (in_valid) begin
            push_word = merged;
            push = (bc == 2'd3) || in_flush;
         end else if (in_flush && (bc != 2'd0)) begin
            push = 1'b1;
         end
      end

      assign full   = (count == DEPTH_CNT);
      assign pop    = rd_en[k] && (count != '0);
      assign accept = push && (!full || pop);
      assign drop   = push && full && !pop;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            bc  <= 2'd0;
            acc <= 32'h0;
         end else if (push) begin
            bc  <= 2'd0;
            acc <= 32'h0;
         end else if (in_valid) begin
            bc  <= bc + 2'd1;
            acc <= merged;
         end
      end

      // Storage needs no reset: the pointers and count define what is valid.
      always_ff @(posedge clk) begin
         if (accept) mem[wr_ptr] <= push_word;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= 32'h0;
            rd_valid <= 1'b0;
            ovf_flag <= 1'b0;
         end else begin
            rd_valid <= pop;
            if (pop) begin
               rd_data <= mem[rd_ptr];
               rd_ptr  <= rd_ptr + ADDR_W'(1);
            end
            if (accept) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (accept && !pop)      count <= count + (ADDR_W + 1)'(1);
            else if (!accept && pop) count <= count - (ADDR_W + 1)'(1);
            if (drop) ovf_flag <= 1'b1;
         end
      end

      assign data_to_arb[32*k +: 32] = rd_data;
      assign valid_to_arb[k]         = rd_valid;
      assign empty_to_arb[k]         = (count == '0);
      assign overflow[k]             = ovf_flag;

`ifdef CORE_OUT_PACKER_OVF_CNT_EN
      logic [7:0] drops;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) drops <= 8'h00;
         else if (drop && (drops != 8'hFF)) drops <= drops + 8'h01;
      end
      assign ovf_count[8*k +: 8] = drops;
`else
      assign ovf_count[8*k +: 8] = 8'h00;
`endif
   end

endmodule

// File: tb/tb_core_out_packer.sv
// Scoreboard bench for core_out_packer: a queue-based lane model predicts words, a monitor checks reads.
module tb_core_out_packer;
   localparam int DEPTH = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [63:0]  core_dout;
   logic [7:0]   core_dout_valid;
   logic [7:0]   flush;
   logic [255:0] data_to_arb;
   logic [7:0]   empty_to_arb;
   logic [7:0]   valid_to_arb;
   logic [7:0]   rd_en;
   logic [7:0]   overflow;
   logic [63:0]  ovf_count;

   core_out_packer #(.FIFO_DEPTH(DEPTH), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .core_dout(core_dout), .core_dout_valid(core_dout_valid),
      .flush(flush), .data_to_arb(data_to_arb), .empty_to_arb(empty_to_arb),
      .valid_to_arb(valid_to_arb), .rd_en(rd_en), .overflow(overflow), .ovf_count(ovf_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]  pend  [8][$];
   logic [31:0] mfifo [8][$];
   logic [31:0] exp_q [8][$];
   logic [31:0] last_data [8];
   logic [7:0]  m_ovf;
   int          drops [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] exp_ovf_count();
      logic [63:0] e;
      e = '0;
`ifdef CORE_OUT_PACKER_OVF_CNT_EN
      for (int k = 0; k < 8; k++) e[8*k +: 8] = (drops[k] > 255) ? 8'hFF : 8'(drops[k]);
`endif
      return e;
   endfunction

   function automatic logic [7:0] exp_empty();
      logic [7:0] e;
      for (int k = 0; k < 8; k++) e[k] = (mfifo[k].size() == 0);
      return e;
   endfunction

   // Monitor: every valid must match the next predicted word; without valid the data must hold.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 8; k++) begin
            if (valid_to_arb[k]) begin
               if (exp_q[k].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_valid lane=%0d actual=1 required=0", k);
               end else begin
                  last_data[k] = exp_q[k].pop_front();
                  chk($sformatf("lane%0d_data", k), 64'(data_to_arb[32*k +: 32]), 64'(last_data[k]));
               end
            end else begin
               chk($sformatf("lane%0d_hold", k), 64'(data_to_arb[32*k +: 32]), 64'(last_data[k]));
            end
         end
      end
   end

   task automatic clear_model();
      for (int k = 0; k < 8; k++) begin
         pend[k].delete();
         mfifo[k].delete();
         exp_q[k].delete();
         last_data[k] = 32'h0;
         drops[k] = 0;
      end
      m_ovf = 8'h00;
   endtask

   // One clock: drive inputs, advance the model by the same edge, then check lane status.
   task automatic cycle(input logic [63:0] d, input logic [7:0] v, input logic [7:0] f, input logic [7:0] r);
      logic [31:0] w;
      logic        have_w;
      core_dout = d;
      core_dout_valid = v;
      flush = f;
      rd_en = r;
      for (int k = 0; k < 8; k++) begin
         have_w = 1'b0;
         w = 32'h0;
         if (v[k]) pend[k].push_back(d[8*k +: 8]);
         if (pend[k].size() == 4 || (f[k] && pend[k].size() > 0)) begin
            have_w = 1'b1;
            for (int i = 0; i < pend[k].size(); i++) w = w | ({24'h0, pend[k][i]} << (8 * i));
            pend[k].delete();
         end
         if (r[k] && mfifo[k].size() > 0) exp_q[k].push_back(mfifo[k].pop_front());
         if (have_w) begin
            if (mfifo[k].size() < DEPTH) mfifo[k].push_back(w);
            else begin
               m_ovf[k] = 1'b1;
               drops[k]++;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      chk("empty", 64'(empty_to_arb), 64'(exp_empty()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("ovf_count", ovf_count, exp_ovf_count());
   endtask

   task automatic do_reset();
      #1;
      rst = 1'b1;
      core_dout = '0;
      core_dout_valid = '0;
      flush = '0;
      rd_en = '0;
      clear_model();
      @(negedge clk);
      chk("rst_empty", 64'(empty_to_arb), 64'hFF);
      chk("rst_valid", 64'(valid_to_arb), 64'h0);
      chk("rst_overflow", 64'(overflow), 64'h0);
      chk("rst_data_lo", data_to_arb[63:0], 64'h0);
      chk("rst_data_hi", data_to_arb[255:192], 64'h0);
      chk("rst_ovf_count", ovf_count, 64'h0);
      #1;
      rst = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [63:0] lane_byte(input int k, input logic [7:0] b);
      return 64'(b) << (8 * k);
   endfunction

   initial begin
      rst = 1'b1;
      core_dout = '0;
      core_dout_valid = '0;
      flush = '0;
      rd_en = '0;
      clear_model();
      repeat (3) @(negedge clk);
      do_reset();

      // Lane 0: four bytes form one word.
      cycle(lane_byte(0, 8'h11), 8'h01, 8'h00, 8'h00);
      cycle(lane_byte(0, 8'h22), 8'h01, 8'h00, 8'h00);
      cycle(lane_byte(0, 8'h33), 8'h01, 8'h00, 8'h00);
      chk("t1_empty_before", 64'(empty_to_arb[0]), 64'h1);
      cycle(lane_byte(0, 8'h44), 8'h01, 8'h00, 8'h00);
      chk("t1_empty_after", 64'(empty_to_arb[0]), 64'h0);
      cycle('0, 8'h00, 8'h00, 8'h01);
      chk("t1_valid", 64'(valid_to_arb[0]), 64'h1);
      chk("t1_word", 64'(data_to_arb[31:0]), 64'h44332211);
      cycle('0, 8'h00, 8'h00, 8'h00);
      chk("t1_valid_one_cycle", 64'(valid_to_arb[0]), 64'h0);

      // Lane 3: partial flush, then flush with nothing pending.
      cycle(lane_byte(3, 8'hAA), 8'h08, 8'h00, 8'h00);
      cycle(lane_byte(3, 8'hBB), 8'h08, 8'h00, 8'h00);
      cycle('0, 8'h00, 8'h08, 8'h00);
      cycle('0, 8'h00, 8'h00, 8'h08);
      chk("t2_word", 64'(data_to_arb[127:96]), 64'h0000BBAA);
      cycle('0, 8'h00, 8'h08, 8'h00);
      cycle('0, 8'h00, 8'h00, 8'h00);
      chk("t2_empty_flush_bc0", 64'(empty_to_arb[3]), 64'h1);

      // Lane 5: fourth byte and flush together give exactly one word.
      cycle(lane_byte(5, 8'h01), 8'h20, 8'h00, 8'h00);
      cycle(lane_byte(5, 8'h02), 8'h20, 8'h00, 8'h00);
      cycle(lane_byte(5, 8'h03), 8'h20, 8'h00, 8'h00);
      cycle(lane_byte(5, 8'h04), 8'h20, 8'h20, 8'h00);
      cycle('0, 8'h00, 8'h00, 8'h20);
      chk("t3_word", 64'(data_to_arb[191:160]), 64'h04030201);
      cycle('0, 8'h00, 8'h00, 8'h20);
      chk("t3_single_push", 64'(valid_to_arb[5]), 64'h0);

      // Lane 7: 17 words into a 16-deep FIFO.
      for (int n = 1; n <= 17; n++)
         for (int i = 0; i < 4; i++)
            cycle(lane_byte(7, (i == 0) ? 8'(n) : 8'h00), 8'h80, 8'h00, 8'h00);
      chk("t4_overflow", 64'(overflow[7]), 64'h1);
`ifdef CORE_OUT_PACKER_OVF_CNT_EN
      chk("t4_ovf_count", 64'(ovf_count[63:56]), 64'h1);
`else
      chk("t4_ovf_count", 64'(ovf_count[63:56]), 64'h0);
`endif
      for (int n = 1; n <= 16; n++) begin
         cycle('0, 8'h00, 8'h00, 8'h80);
         chk("t4_valid", 64'(valid_to_arb[7]), 64'h1);
         chk("t4_order", 64'(data_to_arb[255:224]), 64'(n));
      end
      cycle('0, 8'h00, 8'h00, 8'h80);
      chk("t4_read_empty", 64'(valid_to_arb[7]), 64'h0);

      // All lanes concurrently, then a read burst.
      for (int j = 0; j < 12; j++) cycle({$urandom, $urandom}, 8'hFF, 8'h00, 8'h00);
      repeat (3) cycle('0, 8'h00, 8'h00, 8'hFF);
      cycle('0, 8'h00, 8'h00, 8'hFF);
      chk("t5_all_drained", 64'(valid_to_arb), 64'h0);

      // Reset mid-packing and with queued words.
      cycle(lane_byte(1, 8'h5A), 8'h02, 8'h00, 8'h00);
      cycle(lane_byte(1, 8'h6B), 8'h02, 8'h00, 8'h00);
      for (int j = 0; j < 12; j++) cycle(lane_byte(2, 8'(j + 1)), 8'h04, 8'h00, 8'h00);
      do_reset();
      cycle(lane_byte(1, 8'hA1), 8'h02, 8'h00, 8'h00);
      cycle(lane_byte(1, 8'hA2), 8'h02, 8'h00, 8'h00);
      cycle(lane_byte(1, 8'hA3), 8'h02, 8'h00, 8'h00);
      cycle(lane_byte(1, 8'hA4), 8'h02, 8'h00, 8'h00);
      cycle('0, 8'h00, 8'h00, 8'h02);
      chk("t6_fresh_word", 64'(data_to_arb[63:32]), 64'hA4A3A2A1);

      // Randomized traffic with phases of light and heavy reading.
      for (int j = 0; j < 3000; j++) begin
         logic [7:0] rdm;
         rdm = ((j / 500) % 2 == 0) ? 8'($urandom & $urandom & $urandom) : 8'($urandom | $urandom);
         cycle({$urandom, $urandom}, 8'($urandom), 8'($urandom & $urandom & $urandom), rdm);
      end
      repeat (40) cycle('0, 8'h00, 8'h00, 8'hFF);
      for (int k = 0; k < 8; k++) chk($sformatf("pending_lane%0d", k), 64'(exp_q[k].size()), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/core_out_packer.md
Name: core_out_packer

Overview:
- Per-core output stage for the 8 NeuRRAM cores.
- Packs each core's 8-bit output samples into 32-bit words and buffers them in 8 independent lane FIFOs.
- Presents data/empty/valid to the pipe-out arbiter and accepts per-lane rd_en from it.
- Single clock domain (clk); the arbiter performs the ok_clk crossing downstream.

Parameters:
- FIFO_DEPTH, 16, words per lane FIFO; power of two, min 4.
- ADDR_W, 4, log2(FIFO_DEPTH); pointer width.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- core_dout  input  64  byte k = sample from core k, bits [8k+7:8k]
- core_dout_valid  input  8  bit k qualifies byte k for one cycle
- flush  input  8  bit k: emit lane k partial word, zero-padded
- data_to_arb  output  256  lane k word at bits [32k+31:32k], registered
- empty_to_arb  output  8  bit k high when lane k FIFO holds 0 words
- valid_to_arb  output  8  bit k high the cycle after an accepted read of lane k
- rd_en  input  8  per-lane read request from arbiter
- overflow  output  8  sticky per-lane flag: a word was dropped because the FIFO was full
- ovf_count  output  64  per-lane 8-bit saturating drop count (optional feature)

Behaviour:
- Reset values:
  - all FIFOs empty; empty_to_arb = 8'hFF
  - valid_to_arb = 0, data_to_arb = 0, overflow = 0, ovf_count = 0
  - packer byte counters = 0, accumulators = 0
- Packer per lane, 2-bit byte counter bc plus 32-bit accumulator acc:
  - Accepted sample is placed little-endian: first byte at [7:0], fourth at [31:24].
  - Fourth byte (bc = 3): the completed word {byte, acc[23:0]} is pushed to the FIFO the same cycle; bc wraps to 0 and acc clears.
  - flush with bc > 0: acc is pushed with unfilled bytes = 0; bc and acc clear.
  - flush with bc = 0: no push.
  - flush and valid in the same cycle: the sample is packed first, then the flush applies.
    - If the sample completes a word, exactly one push occurs.
    - Otherwise the partial word including the new byte is pushed.
  - At most one push per lane per cycle.
- Lane FIFO:
  - Circular buffer with wr_ptr/rd_ptr of ADDR_W bits and a count of ADDR_W+1 bits.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push while full (count = FIFO_DEPTH):
    - The word is dropped and overflow[k] sets; it stays set until rst.
    - The packer still clears, so the byte stream resumes aligned.
  - Simultaneous push and pop on a full FIFO: the pop frees space and the push is accepted.
- Read side (standard, non-FWFT):
  - rd_en[k] with empty_to_arb[k] = 0 pops the word into data_to_arb lane k on the next clk edge and raises valid_to_arb[k] for exactly that cycle.
  - rd_en on an empty lane is ignored: no pointer move, valid stays low, data holds its last value.
  - Back-to-back rd_en gives one word per cycle, so read latency is 1.
  - empty_to_arb is combinational from count (count = 0).
  - A push becomes visible on empty_to_arb the cycle after the push edge.
- Lanes are fully independent; no arbitration inside this block.
- rst asserted mid-packing discards partial words and FIFO contents immediately.

Optional Feature:
- Macro: CORE_OUT_PACKER_OVF_CNT_EN.
- Defined: ovf_count lane k counts dropped words, saturating at 8'hFF and clearing only on rst.
- Undefined: ovf_count is tied to 0, there are no counter registers, and overflow still works.

Test Plan:
- Lane 0 bytes 11,22,33,44 on four valid cycles, then rd_en[0] once -> empty_to_arb[0] falls the cycle after the 4th byte; next cycle valid_to_arb[0] = 1, data lane 0 = 32'h44332211.
- Lane 3 bytes AA,BB then flush[3] -> word 32'h0000BBAA; flush with bc = 0 -> no new word, empty_to_arb[3] stays 1.
- Lane 5 bytes 01,02,03 then byte 04 with flush[5] the same cycle -> exactly one word 32'h04030201.
- Lane 7: 17 words with no reads (FIFO_DEPTH = 16) -> overflow[7] = 1, ovf_count[63:56] = 1 if enabled; 16 reads return words 1..16 in order; 17th rd_en gives no valid.
- All 8 lanes written concurrently, with rd_en = 8'hFF held for 3 cycles -> each lane returns its own words with no cross-lane mixing; extra rd_en on an empty lane is ignored.
- rst pulsed after 2 bytes on lane 1 and 3 queued words on lane 2 -> all empty, valid = 0, overflow = 0; the next 4 bytes on lane 1 form a fresh aligned word.
